// File: rtl/axil_cmd_pkg.sv
`default_nettype none
//==============================================================================
// Package  : axil_cmd_pkg
// Brief    : State encoding and AXI response codes shared by axil_cmd_master.
// Revision : 1.0
//==============================================================================
package axil_cmd_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_WR_REQ = 3'd1;
    localparam logic [ST_W-1:0] ST_WR_RSP = 3'd2;
    localparam logic [ST_W-1:0] ST_RD_REQ = 3'd3;
    localparam logic [ST_W-1:0] ST_RD_RSP = 3'd4;
    localparam logic [ST_W-1:0] ST_RSP    = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage : axil_cmd_pkg
`default_nettype wire

// File: rtl/axil_cmd_master_if.sv
`default_nettype none
//==============================================================================
// Interface : axil_cmd_master_if
// Brief     : AXI4-Lite bus bundle with master and slave views.
// Revision  : 1.0
//==============================================================================
interface axil_cmd_master_if
    import axil_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface : axil_cmd_master_if
`default_nettype wire

// File: rtl/axil_cmd_master.sv
`default_nettype none
//==============================================================================
// Module   : axil_cmd_master
// Brief    : Single-outstanding AXI4-Lite master driven by a cmd/rsp handshake,
//            with a sticky per-transaction timeout flag.
// Revision : 1.0
//==============================================================================
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 64
)(
    input  wire                   clk,
    input  wire                   rst_n,

    input  wire                   cmd_valid,
    output logic                  cmd_ready,
    input  wire                   cmd_write,
    input  wire  [ADDR_WIDTH-1:0] cmd_addr,
    input  wire  [DATA_WIDTH-1:0] cmd_wdata,
    input  wire  [STRB_WIDTH-1:0] cmd_wstrb,
    input  wire  [2:0]            cmd_prot,

    output logic                  rsp_valid,
    input  wire                   rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic                  busy,
    output logic                  timeout,

    axil_cmd_master_if.master     m_axil
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(TIMEOUT - 1);

    logic [ST_W-1:0]       r_state;
    logic                  r_aw_done;
    logic                  r_w_done;

    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [2:0]            r_awprot;
    logic                  r_awvalid;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [2:0]            r_arprot;
    logic                  r_arvalid;
    logic                  r_rready;

    logic                  r_rsp_valid;
    logic                  r_rsp_write;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [1:0]            r_rsp_resp;

    logic [CNT_W-1:0]      r_cnt;
    logic                  r_timeout;

    logic                  w_accept;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_aw_done_nxt;
    logic                  w_w_done_nxt;
    logic                  w_cnt_en;
    logic [CNT_W-1:0]      w_cnt_nxt;

    assign w_accept      = (r_state == ST_IDLE) && cmd_valid;
    assign w_aw_hs       = r_awvalid && m_axil.awready;
    assign w_w_hs        = r_wvalid  && m_axil.wready;
    assign w_ar_hs       = r_arvalid && m_axil.arready;
    assign w_aw_done_nxt = r_aw_done || w_aw_hs;
    assign w_w_done_nxt  = r_w_done  || w_w_hs;

    // Transaction FSM; every AXI-facing output is a flop so the bus sees no glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awaddr    <= '0;
            r_awprot    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arprot    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= RESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_awaddr  <= cmd_addr;
                        r_araddr  <= cmd_addr;
                        r_awprot  <= cmd_prot;
                        r_arprot  <= cmd_prot;
                        r_wdata   <= cmd_wdata;
                        r_wstrb   <= cmd_wstrb;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_REQ;
                        end
                    end
                end

                ST_WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    r_aw_done <= w_aw_done_nxt;
                    r_w_done  <= w_w_done_nxt;
                    // AW and W may finish in any order; B is only solicited once both have.
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RSP;
                    end
                end

                ST_WR_RSP: begin
                    if (m_axil.bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= m_axil.bresp;
                        r_rsp_write <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end

                ST_RD_REQ: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_RSP;
                    end
                end

                ST_RD_RSP: begin
                    if (m_axil.rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= m_axil.rdata;
                        r_rsp_resp  <= m_axil.rresp;
                        r_rsp_write <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Counts only cycles spent waiting on the slave; RSP time is the consumer's.
    assign w_cnt_en  = (r_state != ST_IDLE) && (r_state != ST_RSP);
    assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_cnt_en) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt >= CNT_THR) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign timeout   = r_timeout;

    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;

    assign m_axil.awaddr  = r_awaddr;
    assign m_axil.awprot  = r_awprot;
    assign m_axil.awvalid = r_awvalid;
    assign m_axil.wdata   = r_wdata;
    assign m_axil.wstrb   = r_wstrb;
    assign m_axil.wvalid  = r_wvalid;
    assign m_axil.bready  = r_bready;
    assign m_axil.araddr  = r_araddr;
    assign m_axil.arprot  = r_arprot;
    assign m_axil.arvalid = r_arvalid;
    assign m_axil.rready  = r_rready;

endmodule : axil_cmd_master
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_axil_cmd_master
// Brief    : Self-checking bench for axil_cmd_master with a delay-programmable slave.
// Revision : 1.0
//==============================================================================
module tb_axil_cmd_master;
    import axil_cmd_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int SW    = 4;
    localparam int TO    = 8;
    localparam int BOUND = 200;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic [2:0]    cmd_prot  = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          busy;
    logic          timeout;

    axil_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) axi ();

    axil_cmd_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .busy(busy), .timeout(timeout),
        .m_axil(axi)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

    // Cycle index and per-channel handshake tallies, sampled at the active edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (axi.awvalid && axi.awready) aw_cnt <= aw_cnt + 1;
        if (axi.wvalid  && axi.wready)  w_cnt  <= w_cnt + 1;
        if (axi.bvalid  && axi.bready)  b_cnt  <= b_cnt + 1;
        if (axi.arvalid && axi.arready) ar_cnt <= ar_cnt + 1;
        if (axi.rvalid  && axi.rready)  r_cnt  <= r_cnt + 1;
    end

    // ---------------- slave channel models ----------------
    task automatic slave_aw(input logic [AW-1:0] addr, input logic [2:0] prot, input int dly);
        int n = 0;
        while (axi.awvalid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        n_chk++;
        if (n >= BOUND) begin n_fail++; $display("FAIL aw_wait: awvalid never rose"); return; end
        for (int i = 0; i <= dly; i++) begin
            n_chk++;
            if (axi.awvalid !== 1'b1 || axi.awaddr !== addr || axi.awprot !== prot) begin
                n_fail++;
                $display("FAIL aw_stable: awvalid=%b awaddr=%h awprot=%h, required 1/%h/%h",
                         axi.awvalid, axi.awaddr, axi.awprot, addr, prot);
            end
            if (i == dly) axi.awready = 1'b1;
            @(negedge clk);
        end
        axi.awready = 1'b0;
        n_chk++;
        if (axi.awvalid !== 1'b0) begin n_fail++; $display("FAIL aw_drop: awvalid=%b, required 0", axi.awvalid); end
    endtask

    task automatic slave_w(input logic [DW-1:0] data, input logic [SW-1:0] strb, input int dly);
        int n = 0;
        while (axi.wvalid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        n_chk++;
        if (n >= BOUND) begin n_fail++; $display("FAIL w_wait: wvalid never rose"); return; end
        for (int i = 0; i <= dly; i++) begin
            n_chk++;
            if (axi.wvalid !== 1'b1 || axi.wdata !== data || axi.wstrb !== strb) begin
                n_fail++;
                $display("FAIL w_stable: wvalid=%b wdata=%h wstrb=%h, required 1/%h/%h",
                         axi.wvalid, axi.wdata, axi.wstrb, data, strb);
            end
            if (i == dly) axi.wready = 1'b1;
            @(negedge clk);
        end
        axi.wready = 1'b0;
        n_chk++;
        if (axi.wvalid !== 1'b0) begin n_fail++; $display("FAIL w_drop: wvalid=%b, required 0", axi.wvalid); end
    endtask

    task automatic slave_b(input int dly, input logic [1:0] resp);
        int n = 0;
        while (axi.bready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        n_chk++;
        if (n >= BOUND) begin n_fail++; $display("FAIL b_wait: bready never rose"); return; end
        repeat (dly) begin
            n_chk++;
            if (axi.bready !== 1'b1) begin n_fail++; $display("FAIL b_hold: bready=%b, required 1", axi.bready); end
            @(negedge clk);
        end
        axi.bvalid = 1'b1;
        axi.bresp  = resp;
        @(negedge clk);
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        n_chk++;
        if (axi.bready !== 1'b0) begin n_fail++; $display("FAIL b_drop: bready=%b, required 0", axi.bready); end
    endtask

    task automatic slave_ar(input logic [AW-1:0] addr, input logic [2:0] prot, input int dly);
        int n = 0;
        while (axi.arvalid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        n_chk++;
        if (n >= BOUND) begin n_fail++; $display("FAIL ar_wait: arvalid never rose"); return; end
        for (int i = 0; i <= dly; i++) begin
            n_chk++;
            if (axi.arvalid !== 1'b1 || axi.araddr !== addr || axi.arprot !== prot || axi.rready !== 1'b0) begin
                n_fail++;
                $display("FAIL ar_stable: arvalid=%b araddr=%h arprot=%h rready=%b, required 1/%h/%h/0",
                         axi.arvalid, axi.araddr, axi.arprot, axi.rready, addr, prot);
            end
            if (i == dly) axi.arready = 1'b1;
            @(negedge clk);
        end
        axi.arready = 1'b0;
        n_chk++;
        if (axi.arvalid !== 1'b0 || axi.rready !== 1'b1) begin
            n_fail++; $display("FAIL ar_drop: arvalid=%b rready=%b, required 0/1", axi.arvalid, axi.rready);
        end
    endtask

    task automatic slave_r(input int dly, input logic [1:0] resp, input logic [DW-1:0] data);
        int n = 0;
        while (axi.rready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        n_chk++;
        if (n >= BOUND) begin n_fail++; $display("FAIL r_wait: rready never rose"); return; end
        repeat (dly) begin
            n_chk++;
            if (axi.rready !== 1'b1) begin n_fail++; $display("FAIL r_hold: rready=%b, required 1", axi.rready); end
            @(negedge clk);
        end
        axi.rvalid = 1'b1;
        axi.rresp  = resp;
        axi.rdata  = data;
        @(negedge clk);
        axi.rvalid = 1'b0;
        axi.rresp  = 2'b00;
        axi.rdata  = '0;
        n_chk++;
        if (axi.rready !== 1'b0) begin n_fail++; $display("FAIL r_drop: rready=%b, required 0", axi.rready); end
    endtask

    // One command through to response; called at a falling edge, returns at one.
    task automatic run_txn(
        input  logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
        input  logic [SW-1:0] strb, input logic [2:0] prot,
        input  int d_aw, input int d_w, input int d_b, input int d_ar, input int d_r,
        input  logic [1:0] sresp, input logic [DW-1:0] srdata, input int hold,
        output logic o_wr, output logic [DW-1:0] o_rdata, output logic [1:0] o_resp,
        output int o_lat, output int o_acc, output logic o_to);
        fork
            begin
                int   n;
                int   busy_done;
                logic exp_to;
                cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
                cmd_wstrb = strb; cmd_prot = prot; cmd_valid = 1'b1;
                n_chk++;
                if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_idle: got %b, required 1", cmd_ready); end
                o_acc = cyc;
                @(negedge clk);
                cmd_valid = 1'b0;
                busy_done = 0;
                n = 0;
                while (rsp_valid !== 1'b1 && n < BOUND) begin
                    exp_to = (busy_done >= TO - 1);
                    n_chk++;
                    if (busy !== 1'b1 || cmd_ready !== 1'b0 || timeout !== exp_to) begin
                        n_fail++;
                        $display("FAIL busy_state: busy=%b cmd_ready=%b timeout=%b, required 1/0/%b",
                                 busy, cmd_ready, timeout, exp_to);
                    end
                    n_chk++;
                    if ((axi.bready && (axi.awvalid || axi.wvalid)) || (axi.rready && axi.arvalid) ||
                        (axi.bready && !(aw_cnt == b_cnt + 1 && w_cnt == b_cnt + 1)) ||
                        (!wr && axi.bready) || (wr && axi.rready)) begin
                        n_fail++;
                        $display("FAIL chan_order: aw/w/b=%0d/%0d/%0d bready=%b rready=%b awv=%b wv=%b arv=%b",
                                 aw_cnt, w_cnt, b_cnt, axi.bready, axi.rready, axi.awvalid, axi.wvalid, axi.arvalid);
                    end
                    if (n == 0) begin
                        n_chk++;
                        if (wr && (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || axi.arvalid !== 1'b0)) begin
                            n_fail++;
                            $display("FAIL first_cycle_wr: awvalid=%b wvalid=%b arvalid=%b, required 1/1/0",
                                     axi.awvalid, axi.wvalid, axi.arvalid);
                        end else if (!wr && (axi.arvalid !== 1'b1 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0)) begin
                            n_fail++;
                            $display("FAIL first_cycle_rd: arvalid=%b awvalid=%b wvalid=%b, required 1/0/0",
                                     axi.arvalid, axi.awvalid, axi.wvalid);
                        end
                    end
                    busy_done++;
                    n++;
                    @(negedge clk);
                end
                n_chk++;
                if (n >= BOUND) begin n_fail++; $display("FAIL rsp_wait: rsp_valid never rose"); end
                o_lat   = cyc - o_acc;
                o_wr    = rsp_write;
                o_rdata = rsp_rdata;
                o_resp  = rsp_resp;
                exp_to  = (busy_done >= TO - 1);
                for (int h = 0; h <= hold; h++) begin
                    n_chk++;
                    if (rsp_valid !== 1'b1 || rsp_write !== o_wr || rsp_rdata !== o_rdata || rsp_resp !== o_resp ||
                        cmd_ready !== 1'b0 || timeout !== exp_to ||
                        (axi.awvalid | axi.wvalid | axi.arvalid | axi.bready | axi.rready) !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rsp_hold: valid=%b wr=%b rdata=%h resp=%b cmd_ready=%b timeout=%b, required 1/%b/%h/%b/0/%b",
                                 rsp_valid, rsp_write, rsp_rdata, rsp_resp, cmd_ready, timeout,
                                 o_wr, o_rdata, o_resp, exp_to);
                    end
                    if (h == hold) rsp_ready = 1'b1;
                    @(negedge clk);
                end
                rsp_ready = 1'b0;
                n_chk++;
                if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || timeout !== exp_to) begin
                    n_fail++;
                    $display("FAIL rsp_done: rsp_valid=%b cmd_ready=%b busy=%b timeout=%b, required 0/1/0/%b",
                             rsp_valid, cmd_ready, busy, timeout, exp_to);
                end
                o_to = timeout;
            end
            begin if (wr)  slave_aw(addr, prot, d_aw); end
            begin if (wr)  slave_w(wdata, strb, d_w); end
            begin if (wr)  slave_b(d_b, sresp); end
            begin if (!wr) slave_ar(addr, prot, d_ar); end
            begin if (!wr) slave_r(d_r, sresp, srdata); end
        join
    endtask

    // Reference latency and timeout, from channel delays alone.
    function automatic int model_lat(input logic wr, input int d_aw, input int d_w, input int d_b,
                                     input int d_ar, input int d_r);
        if (wr) return 3 + ((d_aw > d_w) ? d_aw : d_w) + d_b;
        return 3 + d_ar + d_r;
    endfunction

    logic          g_wr, g_to;
    logic [DW-1:0] g_rdata;
    logic [1:0]    g_resp;
    int            g_lat, g_acc;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0 || rsp_valid !== 1'b0 ||
            rsp_write !== 1'b0 || rsp_rdata !== '0 || rsp_resp !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_cmd: cmd_ready=%b busy=%b timeout=%b rsp_valid=%b wr=%b rdata=%h resp=%b, required 1/0/0/0/0/0/0",
                     cmd_ready, busy, timeout, rsp_valid, rsp_write, rsp_rdata, rsp_resp);
        end
        n_chk++;
        if ((axi.awvalid | axi.wvalid | axi.bready | axi.arvalid | axi.rready) !== 1'b0 ||
            axi.awaddr !== '0 || axi.araddr !== '0 || axi.wdata !== '0 || axi.wstrb !== '0 ||
            axi.awprot !== '0 || axi.arprot !== '0) begin
            n_fail++;
            $display("FAIL reset_axi: awv=%b wv=%b br=%b arv=%b rr=%b awaddr=%h wdata=%h, required all 0",
                     axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, axi.awaddr, axi.wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic_write();
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 0, 0, 0, 0, RESP_OKAY, '0, 0,
                g_wr, g_rdata, g_resp, g_lat, g_acc, g_to);
        n_chk++;
        if (g_wr !== 1'b1 || g_resp !== RESP_OKAY || g_rdata !== '0 || g_lat != 3 || g_to !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_write: wr=%b resp=%b rdata=%h lat=%0d to=%b, required 1/00/0/3/0",
                     g_wr, g_resp, g_rdata, g_lat, g_to);
        end
    endtask

    task automatic test_w_before_aw();
        int b0 = b_cnt, aw0 = aw_cnt, w0 = w_cnt;
        run_txn(1'b1, 32'h40, 32'hA5A5_0F0F, 4'h3, 3'd2, 3, 0, 0, 0, 0, RESP_EXOKAY, '0, 0,
                g_wr, g_rdata, g_resp, g_lat, g_acc, g_to);
        n_chk++;
        if (g_wr !== 1'b1 || g_resp !== RESP_EXOKAY || g_lat != 6) begin
            n_fail++;
            $display("FAIL w_before_aw: wr=%b resp=%b lat=%0d, required 1/01/6", g_wr, g_resp, g_lat);
        end
        n_chk++;
        if (b_cnt != b0 + 1 || aw_cnt != aw0 + 1 || w_cnt != w0 + 1) begin
            n_fail++;
            $display("FAIL one_b: b/aw/w deltas %0d/%0d/%0d, required 1/1/1", b_cnt - b0, aw_cnt - aw0, w_cnt - w0);
        end
    endtask

    task automatic test_read_slverr();
        run_txn(1'b0, 32'h24, '0, '0, 3'd1, 0, 0, 0, 0, 5, RESP_SLVERR, 32'h12345678, 0,
                g_wr, g_rdata, g_resp, g_lat, g_acc, g_to);
        n_chk++;
        if (g_wr !== 1'b0 || g_rdata !== 32'h12345678 || g_resp !== RESP_SLVERR || g_lat != 8) begin
            n_fail++;
            $display("FAIL read_slverr: wr=%b rdata=%h resp=%b lat=%0d, required 0/12345678/10/8",
                     g_wr, g_rdata, g_resp, g_lat);
        end
    endtask

    task automatic test_rsp_hold();
        run_txn(1'b0, 32'h80, '0, '0, 3'd0, 0, 0, 0, 1, 0, RESP_DECERR, 32'hCAFE_F00D, 10,
                g_wr, g_rdata, g_resp, g_lat, g_acc, g_to);
        n_chk++;
        if (g_wr !== 1'b0 || g_rdata !== 32'hCAFEF00D || g_resp !== RESP_DECERR || g_lat != 4) begin
            n_fail++;
            $display("FAIL rsp_hold_payload: wr=%b rdata=%h resp=%b lat=%0d, required 0/cafef00d/11/4",
                     g_wr, g_rdata, g_resp, g_lat);
        end
    endtask

    task automatic test_timeout();
        // Six busy cycles stays clear, seven sets the flag in the response cycle.
        run_txn(1'b1, 32'h100, 32'h1, 4'h1, 3'd0, 0, 0, 4, 0, 0, RESP_OKAY, '0, 0,
                g_wr, g_rdata, g_resp, g_lat, g_acc, g_to);
        n_chk++;
        if (g_to !== 1'b0 || g_lat != 7) begin n_fail++; $display("FAIL timeout_below: to=%b lat=%0d, required 0/7", g_to, g_lat); end
        run_txn(1'b1, 32'h104, 32'h2, 4'h2, 3'd0, 0, 0, 5, 0, 0, RESP_OKAY, '0, 0,
                g_wr, g_rdata, g_resp, g_lat, g_acc, g_to);
        n_chk++;
        if (g_to !== 1'b1 || g_lat != 8) begin n_fail++; $display("FAIL timeout_edge: to=%b lat=%0d, required 1/8", g_to, g_lat); end
        run_txn(1'b1, 32'h108, 32'h3, 4'h4, 3'd0, 0, 0, 17, 0, 0, RESP_SLVERR, '0, 0,
                g_wr, g_rdata, g_resp, g_lat, g_acc, g_to);
        n_chk++;
        if (g_to !== 1'b1 || g_lat != 20 || g_resp !== RESP_SLVERR) begin
            n_fail++; $display("FAIL timeout_long: to=%b lat=%0d resp=%b, required 1/20/10", g_to, g_lat, g_resp);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b, required 1", timeout); end
        run_txn(1'b0, 32'h10C, '0, '0, 3'd0, 0, 0, 0, 0, 0, RESP_OKAY, 32'h77, 0,
                g_wr, g_rdata, g_resp, g_lat, g_acc, g_to);
        n_chk++;
        if (g_to !== 1'b0 || g_rdata !== 32'h77) begin
            n_fail++; $display("FAIL timeout_clear: to=%b rdata=%h, required 0/77", g_to, g_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int prev_acc = -1;
        for (int t = 0; t < 3; t++) begin
            run_txn(1'(t % 2), 32'(t * 4), 32'(t + 100), 4'hF, 3'd0, 0, 0, 0, 0, 0, RESP_OKAY, 32'(t), 0,
                    g_wr, g_rdata, g_resp, g_lat, g_acc, g_to);
            if (prev_acc >= 0) begin
                n_chk++;
                if (g_acc - prev_acc != 4) begin
                    n_fail++; $display("FAIL back_to_back: spacing %0d, required 4", g_acc - prev_acc);
                end
            end
            prev_acc = g_acc;
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            logic          wr;
            logic [AW-1:0] addr;
            logic [DW-1:0] wd, rd;
            logic [SW-1:0] st;
            logic [2:0]    pr;
            logic [1:0]    rs;
            int            da, dw, db, dar, dr, hold, e_lat;
            logic          e_to;
            wr   = 1'($urandom_range(1, 0));
            addr = $urandom;
            wd   = $urandom;
            rd   = $urandom;
            st   = 4'($urandom_range(15, 1));
            pr   = 3'($urandom_range(7, 0));
            rs   = 2'($urandom_range(3, 0));
            da   = int'($urandom_range(4, 0));
            dw   = int'($urandom_range(4, 0));
            db   = int'($urandom_range(4, 0));
            dar  = int'($urandom_range(4, 0));
            dr   = int'($urandom_range(4, 0));
            hold = int'($urandom_range(3, 0));
            e_lat = model_lat(wr, da, dw, db, dar, dr);
            e_to  = ((e_lat - 1) >= (TO - 1));
            run_txn(wr, addr, wd, st, pr, da, dw, db, dar, dr, rs, rd, hold,
                    g_wr, g_rdata, g_resp, g_lat, g_acc, g_to);
            n_chk++;
            if (g_wr !== wr || g_rdata !== (wr ? '0 : rd) || g_resp !== rs || g_lat != e_lat || g_to !== e_to) begin
                n_fail++;
                $display("FAIL random[%0d]: wr=%b rdata=%h resp=%b lat=%0d to=%b, required %b/%h/%b/%0d/%b",
                         t, g_wr, g_rdata, g_resp, g_lat, g_to, wr, (wr ? '0 : rd), rs, e_lat, e_to);
            end
        end
    endtask

    task automatic test_async_reset();
        cmd_write = 1'b1; cmd_addr = 32'hBEEF; cmd_wdata = 32'h5555; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++;
        if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: awvalid=%b wvalid=%b busy=%b, required 1/1/1", axi.awvalid, axi.wvalid, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_drop: awvalid=%b wvalid=%b busy=%b cmd_ready=%b, required 0/0/0/1",
                     axi.awvalid, axi.wvalid, busy, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (cmd_ready !== 1'b1 || timeout !== 1'b0 || rsp_valid !== 1'b0 || axi.awaddr !== '0) begin
            n_fail++;
            $display("FAIL areset_release: cmd_ready=%b timeout=%b rsp_valid=%b awaddr=%h, required 1/0/0/0",
                     cmd_ready, timeout, rsp_valid, axi.awaddr);
        end
        run_txn(1'b0, 32'h200, '0, '0, 3'd0, 0, 0, 0, 0, 0, RESP_OKAY, 32'hFEED, 0,
                g_wr, g_rdata, g_resp, g_lat, g_acc, g_to);
        n_chk++;
        if (g_rdata !== 32'hFEED || g_lat != 3) begin
            n_fail++; $display("FAIL areset_recover: rdata=%h lat=%0d, required feed/3", g_rdata, g_lat);
        end
    endtask

    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid  = 1'b0; axi.bresp  = 2'b00;
        axi.rvalid  = 1'b0; axi.rresp  = 2'b00; axi.rdata = '0;
        @(negedge clk);
        test_reset();
        test_basic_write();
        test_w_before_aw();
        test_read_slverr();
        test_rsp_hold();
        test_timeout();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_axil_cmd_master
`default_nettype wire
